// File: rtl/snake_move.sv
// Snake body engine: advances the head one cell per accepted move_en strobe,
// shifts the segment buffer and flags wall and self collisions.
// Ports:
//   lcd_pclk, rst          clock, synchronous active-high reset
//   move_en, pause         step strobe; pause blocks strobes while high
//   key_dir                one-hot {up, down, left, right} direction request
//   grow                   food-eaten pulse, lengthens the snake on the next step
//   rd_idx -> rd_x/rd_y/rd_vld   registered segment read port (0 = head)
//   head_x, head_y, length current head position and snake length
//   game_over, step_done   sticky collision flag, step-commit pulse
module snake_move #(
    parameter int unsigned GRID_W   = 32,
    parameter int unsigned GRID_H   = 24,
    parameter int unsigned MAX_LEN  = 16,
    parameter int unsigned INIT_LEN = 3,
    parameter int unsigned XW       = 8,
    parameter int unsigned YW       = 8,
    parameter int unsigned IW       = 5
) (
    input  logic          lcd_pclk,
    input  logic          rst,
    input  logic          move_en,
    input  logic [3:0]    key_dir,
    input  logic          grow,
    input  logic          pause,
    input  logic [IW-1:0] rd_idx,
    output logic [XW-1:0] rd_x,
    output logic [YW-1:0] rd_y,
    output logic          rd_vld,
    output logic [XW-1:0] head_x,
    output logic [YW-1:0] head_y,
    output logic [IW-1:0] length,
    output logic          game_over,
    output logic          step_done
);

    localparam int unsigned AW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;

    typedef enum logic [1:0] {S_IDLE, S_SCAN, S_UPDATE, S_OVER} state_t;
    typedef enum logic [1:0] {D_UP, D_DOWN, D_LEFT, D_RIGHT} dir_t;

    state_t        state, state_nx;
    dir_t          dir, pend_dir;
    logic [XW-1:0] seg_x [MAX_LEN];
    logic [YW-1:0] seg_y [MAX_LEN];
    logic [XW-1:0] nx_x;
    logic [YW-1:0] nx_y;
    logic [IW-1:0] idx;
    logic          grow_pend;

    logic          commit_c;
    logic          wall_c;
    logic          hit_c;
    logic          last_c;
    logic          key_vld_c;
    logic          load_pend_c;
    dir_t          key_c;
    dir_t          ref_dir_c;
    logic [XW-1:0] step_x_c;
    logic [YW-1:0] step_y_c;

    assign head_x = seg_x[0];
    assign head_y = seg_y[0];

    function automatic dir_t opposite(input dir_t d);
        case (d)
            D_UP:    return D_DOWN;
            D_DOWN:  return D_UP;
            D_LEFT:  return D_RIGHT;
            default: return D_LEFT;
        endcase
    endfunction

    // Decode the key request; reversal is judged against the direction that
    // will be committed after this edge so a same-cycle commit is honoured.
    always_comb begin
        key_vld_c = $onehot(key_dir);
        key_c     = D_RIGHT;
        case (key_dir)
            4'b1000: key_c = D_UP;
            4'b0100: key_c = D_DOWN;
            4'b0010: key_c = D_LEFT;
            default: key_c = D_RIGHT;
        endcase
        ref_dir_c   = commit_c ? pend_dir : dir;
        load_pend_c = key_vld_c && (key_c != opposite(ref_dir_c));
    end

    // Candidate next head plus wall test, evaluated before any add/subtract.
    always_comb begin
        step_x_c = seg_x[0];
        step_y_c = seg_y[0];
        wall_c   = 1'b0;
        case (pend_dir)
            D_UP: begin
                wall_c   = (seg_y[0] == '0);
                step_y_c = seg_y[0] - YW'(1);
            end
            D_DOWN: begin
                wall_c   = (seg_y[0] == YW'(GRID_H - 1));
                step_y_c = seg_y[0] + YW'(1);
            end
            D_LEFT: begin
                wall_c   = (seg_x[0] == '0);
                step_x_c = seg_x[0] - XW'(1);
            end
            default: begin
                wall_c   = (seg_x[0] == XW'(GRID_W - 1));
                step_x_c = seg_x[0] + XW'(1);
            end
        endcase
    end

    // Body compare for the segment under scan; the tail is exempt unless growing.
    always_comb begin
        last_c = (idx == length - IW'(1));
        hit_c  = (seg_x[AW'(idx)] == nx_x) && (seg_y[AW'(idx)] == nx_y)
                 && !(last_c && !grow_pend);
    end

    // State register
    always_ff @(posedge lcd_pclk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nx;
    end

    // Next-state logic
    always_comb begin
        state_nx = state;
        commit_c = 1'b0;
        case (state)
            S_IDLE: begin
                if (move_en && !pause) begin
                    commit_c = 1'b1;
                    state_nx = wall_c ? S_OVER : S_SCAN;
                end
            end
            S_SCAN: begin
                if (hit_c)       state_nx = S_OVER;
                else if (last_c) state_nx = S_UPDATE;
            end
            S_UPDATE: state_nx = S_IDLE;
            S_OVER:   state_nx = S_OVER;
            default:  state_nx = S_IDLE;
        endcase
    end

    // Datapath: direction, segment buffer, length, flags and read port
    always_ff @(posedge lcd_pclk) begin
        if (rst) begin
            for (int i = 0; i < int'(MAX_LEN); i++) begin
                if (i < int'(INIT_LEN)) begin
                    seg_x[AW'(i)] <= XW'(int'(GRID_W / 2) - i);
                    seg_y[AW'(i)] <= YW'(GRID_H / 2);
                end else begin
                    seg_x[AW'(i)] <= '0;
                    seg_y[AW'(i)] <= '0;
                end
            end
            dir       <= D_RIGHT;
            pend_dir  <= D_RIGHT;
            length    <= IW'(INIT_LEN);
            grow_pend <= 1'b0;
            idx       <= '0;
            nx_x      <= '0;
            nx_y      <= '0;
            game_over <= 1'b0;
            step_done <= 1'b0;
            rd_x      <= '0;
            rd_y      <= '0;
            rd_vld    <= 1'b0;
        end else begin
            step_done <= 1'b0;
            if (load_pend_c) pend_dir <= key_c;
            if (commit_c) begin
                dir  <= pend_dir;
                nx_x <= step_x_c;
                nx_y <= step_y_c;
                idx  <= '0;
            end
            if (state == S_SCAN) idx <= idx + IW'(1);
            if (state_nx == S_OVER) game_over <= 1'b1;
            // A grow arriving during UPDATE is consumed by this step.
            grow_pend <= (state == S_UPDATE) ? 1'b0 : (grow_pend | grow);
            if (state == S_UPDATE) begin
                for (int i = int'(MAX_LEN) - 1; i > 0; i--) begin
                    seg_x[AW'(i)] <= seg_x[AW'(i - 1)];
                    seg_y[AW'(i)] <= seg_y[AW'(i - 1)];
                end
                seg_x[0] <= nx_x;
                seg_y[0] <= nx_y;
                if ((grow_pend || grow) && (length < IW'(MAX_LEN)))
                    length <= length + IW'(1);
                step_done <= 1'b1;
            end
            rd_vld <= (rd_idx < length);
            if (32'(rd_idx) < MAX_LEN) begin
                rd_x <= seg_x[AW'(rd_idx)];
                rd_y <= seg_y[AW'(rd_idx)];
            end else begin
                rd_x <= '0;
                rd_y <= '0;
            end
        end
    end

endmodule

// File: tb/tb_snake_move.sv
// Bench for snake_move: constant tables for reset readback and direction
// handling, hand sequences for wall/self/grow/pause/reset corners, and a
// randomized walk compared against a queue-based model of the snake.
module tb_snake_move;

    localparam int unsigned GRID_W   = 32;
    localparam int unsigned GRID_H   = 24;
    localparam int unsigned MAX_LEN  = 16;
    localparam int unsigned INIT_LEN = 3;
    localparam int unsigned XW       = 8;
    localparam int unsigned YW       = 8;
    localparam int unsigned IW       = 5;

    logic          lcd_pclk = 1'b0;
    logic          rst      = 1'b1;
    logic          move_en  = 1'b0;
    logic [3:0]    key_dir  = 4'b0;
    logic          grow     = 1'b0;
    logic          pause    = 1'b0;
    logic [IW-1:0] rd_idx   = '0;
    logic [XW-1:0] rd_x;
    logic [YW-1:0] rd_y;
    logic          rd_vld;
    logic [XW-1:0] head_x;
    logic [YW-1:0] head_y;
    logic [IW-1:0] length;
    logic          game_over;
    logic          step_done;

    snake_move #(
        .GRID_W(GRID_W), .GRID_H(GRID_H), .MAX_LEN(MAX_LEN), .INIT_LEN(INIT_LEN),
        .XW(XW), .YW(YW), .IW(IW)
    ) dut (
        .lcd_pclk(lcd_pclk), .rst(rst), .move_en(move_en), .key_dir(key_dir),
        .grow(grow), .pause(pause), .rd_idx(rd_idx), .rd_x(rd_x), .rd_y(rd_y),
        .rd_vld(rd_vld), .head_x(head_x), .head_y(head_y), .length(length),
        .game_over(game_over), .step_done(step_done)
    );

    always #5 lcd_pclk = ~lcd_pclk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Reference model: body as coordinate queues, head first.
    int mx[$];
    int my[$];
    int m_dir, m_pend;
    bit m_gp, m_over;
    int dxv[4] = '{0, 0, -1, 1};   // up, down, left, right
    int dyv[4] = '{-1, 1, 0, 0};

    function automatic int key_to_dir(input logic [3:0] k);
        if ($countones(k) != 1) return -1;
        if (k[3]) return 0;
        if (k[2]) return 1;
        if (k[1]) return 2;
        return 3;
    endfunction

    task automatic model_reset();
        mx.delete();
        my.delete();
        for (int i = 0; i < int'(INIT_LEN); i++) begin
            mx.push_back(int'(GRID_W / 2) - i);
            my.push_back(int'(GRID_H / 2));
        end
        m_dir  = 3;
        m_pend = 3;
        m_gp   = 1'b0;
        m_over = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge lcd_pclk);
        rst = 1'b1; move_en = 1'b0; key_dir = 4'b0; grow = 1'b0;
        @(negedge lcd_pclk);
        check("rst rd_vld", int'(rd_vld), 0);
        check("rst rd_x", int'(rd_x), 0);
        check("rst game_over", int'(game_over), 0);
        check("rst step_done", int'(step_done), 0);
        check("rst length", int'(length), 3);
        check("rst head_x", int'(head_x), 16);
        check("rst head_y", int'(head_y), 12);
        rst = 1'b0;
        model_reset();
    endtask

    task automatic press(input logic [3:0] k);
        int d;
        @(negedge lcd_pclk) key_dir = k;
        @(negedge lcd_pclk) key_dir = 4'b0;
        d = key_to_dir(k);
        if (d >= 0 && !(dxv[d] + dxv[m_dir] == 0 && dyv[d] + dyv[m_dir] == 0))
            m_pend = d;
    endtask

    task automatic grow_pulse();
        @(negedge lcd_pclk) grow = 1'b1;
        @(negedge lcd_pclk) grow = 1'b0;
        m_gp = 1'b1;
    endtask

    task automatic no_step_for(input string tag, input int n);
        int seen = 0;
        repeat (n) begin
            if (step_done) seen++;
            @(negedge lcd_pclk);
        end
        check({tag, " no step_done"}, seen, 0);
        check({tag, " head_x held"}, int'(head_x), mx[0]);
        check({tag, " head_y held"}, int'(head_y), my[0]);
        check({tag, " length held"}, int'(length), mx.size());
    endtask

    // One step: predict outcome and latency from the model, then watch the DUT.
    task automatic step_check(input string tag, input bit poke);
        int nx, ny, L, hit_k, exp_cyc, cyc;
        bit exp_over, got_done, got_over;
        L = mx.size();
        if (m_over) begin
            @(negedge lcd_pclk) move_en = 1'b1;
            @(negedge lcd_pclk) move_en = 1'b0;
            no_step_for({tag, " over"}, L + 6);
            check({tag, " game_over sticky"}, int'(game_over), 1);
            return;
        end
        nx = mx[0] + dxv[m_pend];
        ny = my[0] + dyv[m_pend];
        exp_over = 1'b0;
        hit_k = -1;
        if (nx < 0 || nx >= int'(GRID_W) || ny < 0 || ny >= int'(GRID_H)) begin
            exp_over = 1'b1;
            exp_cyc  = 1;
        end else begin
            for (int i = 0; i < L; i++)
                if (hit_k < 0 && mx[i] == nx && my[i] == ny && !(i == L - 1 && !m_gp))
                    hit_k = i;
            if (hit_k >= 0) begin
                exp_over = 1'b1;
                exp_cyc  = hit_k + 2;
            end else begin
                exp_cyc = L + 2;
            end
        end
        @(negedge lcd_pclk) move_en = 1'b1;
        @(negedge lcd_pclk) move_en = 1'b0;
        cyc = 1; got_done = 1'b0; got_over = 1'b0;
        while (cyc <= 40 && !got_done && !got_over) begin
            if (step_done) got_done = 1'b1;
            else if (game_over) got_over = 1'b1;
            else begin
                move_en = poke && (cyc == 1);
                @(negedge lcd_pclk);
                cyc++;
            end
        end
        move_en = 1'b0;
        check({tag, " ends in over"}, int'(got_over), int'(exp_over));
        check({tag, " latency"}, cyc, exp_cyc);
        m_dir = m_pend;
        if (exp_over) begin
            m_over = 1'b1;
        end else begin
            mx.push_front(nx);
            my.push_front(ny);
            if (!(m_gp && L < int'(MAX_LEN))) begin
                void'(mx.pop_back());
                void'(my.pop_back());
            end
            m_gp = 1'b0;
        end
        check({tag, " head_x"}, int'(head_x), mx[0]);
        check({tag, " head_y"}, int'(head_y), my[0]);
        check({tag, " length"}, int'(length), mx.size());
        if (got_done) begin
            @(negedge lcd_pclk);
            check({tag, " step_done one cycle"}, int'(step_done), 0);
        end
        if (poke) no_step_for({tag, " dropped move_en"}, L + 6);
    endtask

    task automatic check_segs(input string tag);
        for (int i = 0; i <= mx.size(); i++) begin
            @(negedge lcd_pclk) rd_idx = IW'(i);
            @(negedge lcd_pclk);
            check({tag, " rd_vld"}, int'(rd_vld), int'(i < mx.size()));
            if (i < mx.size()) begin
                check({tag, " rd_x"}, int'(rd_x), mx[i]);
                check({tag, " rd_y"}, int'(rd_y), my[i]);
            end
        end
    endtask

    typedef struct {
        logic [IW-1:0] idx;
        int x, y, vld;
        bit chk_xy;
    } rvec_t;

    typedef struct {
        logic [3:0] key;
        int ex, ey;
    } kvec_t;

    rvec_t rtab[6];
    kvec_t ktab[6];

    initial begin
        rtab = '{'{5'd0, 16, 12, 1, 1'b1}, '{5'd1, 15, 12, 1, 1'b1},
                 '{5'd2, 14, 12, 1, 1'b1}, '{5'd3, 0, 0, 0, 1'b1},
                 '{5'd15, 0, 0, 0, 1'b1},  '{5'd31, 0, 0, 0, 1'b0}};
        ktab = '{'{4'b0000, 17, 12}, '{4'b0010, 18, 12}, '{4'b1100, 19, 12},
                 '{4'b1000, 19, 11}, '{4'b0100, 19, 10}, '{4'b0001, 20, 10}};

        do_reset();

        // Reset readback table
        foreach (rtab[i]) begin
            @(negedge lcd_pclk) rd_idx = rtab[i].idx;
            @(negedge lcd_pclk);
            check("reset rd_vld", int'(rd_vld), rtab[i].vld);
            if (rtab[i].chk_xy) begin
                check("reset rd_x", int'(rd_x), rtab[i].x);
                check("reset rd_y", int'(rd_y), rtab[i].y);
            end
        end

        // Direction table: key (0 = none) then one step
        foreach (ktab[i]) begin
            if (ktab[i].key != 4'b0) press(ktab[i].key);
            step_check("dir step", 1'b0);
            check("dir tbl head_x", int'(head_x), ktab[i].ex);
            check("dir tbl head_y", int'(head_y), ktab[i].ey);
            if (i == 0) check_segs("first step");
        end

        // Wall: climb to y=0 then step into the wall
        do_reset();
        press(4'b1000);
        repeat (12) step_check("up", 1'b0);
        check("wall approach head_y", int'(head_y), 0);
        step_check("wall", 1'b0);
        check("wall game_over", int'(game_over), 1);
        check("wall head_y", int'(head_y), 0);
        step_check("after wall", 1'b0);

        // Growth, including saturation at MAX_LEN
        do_reset();
        grow_pulse();
        step_check("grow", 1'b0);
        check("grow length", int'(length), 4);
        check_segs("grow");
        while (mx.size() < int'(MAX_LEN)) begin
            grow_pulse();
            step_check("grow up", 1'b0);
        end
        grow_pulse();
        step_check("grow at max", 1'b0);
        check("max length", int'(length), 16);
        check_segs("max");

        // Self collision: length 5, then up, left, down
        do_reset();
        grow_pulse(); step_check("self g1", 1'b0);
        grow_pulse(); step_check("self g2", 1'b0);
        check("self length", int'(length), 5);
        press(4'b1000); step_check("self up", 1'b0);
        press(4'b0010); step_check("self left", 1'b0);
        press(4'b0100); step_check("self down", 1'b0);
        check("self game_over", int'(game_over), 1);

        // Pause blocks the strobe; move_en during SCAN is dropped
        do_reset();
        @(negedge lcd_pclk) pause = 1'b1;
        @(negedge lcd_pclk) move_en = 1'b1;
        @(negedge lcd_pclk) move_en = 1'b0;
        no_step_for("pause", 10);
        pause = 1'b0;
        step_check("poke", 1'b1);

        // Reset mid-SCAN aborts the step and drops a pending grow
        do_reset();
        grow_pulse();
        @(negedge lcd_pclk) move_en = 1'b1;
        @(negedge lcd_pclk) move_en = 1'b0;
        @(negedge lcd_pclk);
        do_reset();
        no_step_for("abort", 8);
        step_check("after abort", 1'b0);
        check("after abort length", int'(length), 3);

        // Randomized walk against the model
        do_reset();
        for (int it = 0; it < 150; it++) begin
            int r;
            r = int'($urandom_range(0, 9));
            if (r < 3)      press(4'($urandom_range(0, 15)));
            else if (r < 4) grow_pulse();
            else            step_check("rand", 1'b0);
            if (m_over) do_reset();
            else if (it % 15 == 0) check_segs("rand");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
